// File: rtl/addsub_pkg.sv
// Shared helpers for the pipelined adder/subtractor: chunk sizing and the
// per-stage control payload that travels alongside the operand registers.
package addsub_pkg;

   function automatic int chunk_width(input int width, input int stages);
      return width / stages;
   endfunction

   typedef struct packed {
      logic carry;
      logic sub;
      logic ovf;
   } stage_ctl_t;

endpackage

// File: rtl/addsub_slice.sv
// CW-bit ripple of XOR3 sum cells with majority carry; B is conditionally
// inverted so the same chain serves both add and subtract.
module addsub_slice #(
   parameter int CW = 4
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          sub,
   input  logic          cin,
   output logic [CW-1:0] s,
   output logic          cout,
   output logic          c_msb_in
);

   logic [CW-1:0] bp;
   logic [CW:0]   c;

   assign bp   = b ^ {CW{sub}};
   assign c[0] = cin;

   for (genvar i = 0; i < CW; i++) begin : g_bit
      assign s[i]   = a[i] ^ bp[i] ^ c[i];
      assign c[i+1] = (a[i] & bp[i]) | (a[i] & c[i]) | (bp[i] & c[i]);
   end

   assign cout     = c[CW];
   assign c_msb_in = c[CW-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor resolving one CW-bit carry chunk per
// stage, with valid/ready flow control that compresses bubbles.
module addsub_pipe
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             Clk,
   input  logic             Rst_,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sub,
   output logic             Out_Valid,
   input  logic             Out_Ready,
   output logic [WIDTH-1:0] Y,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int CW = chunk_width(WIDTH, STAGES);

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("addsub_pipe: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   // Handshake: a beat moves into stage k on load[k]; it leaves on adv[k].
   // A stage advances when it holds a beat and the next slot is empty or
   // itself advancing; the last slot advances on Out_Ready.
   logic [STAGES-1:0] v_q, v_d, adv, load;

   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] y_q [STAGES];
   logic [WIDTH-1:0] a_d [STAGES];
   logic [WIDTH-1:0] b_d [STAGES];
   logic [WIDTH-1:0] y_d [STAGES];
   stage_ctl_t       ctl_q [STAGES];
   stage_ctl_t       ctl_d [STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CW-1:0]    sa, sb, s;
      logic [WIDTH-1:0] y_prev;
      logic             ssub, scin, scout, scmsb;

      if (k == 0) begin : g_first
         assign sa     = A[CW-1:0];
         assign sb     = B[CW-1:0];
         assign ssub   = Sub;
         assign scin   = Sub;
         assign a_d[k] = A;
         assign b_d[k] = B;
         assign y_prev = '0;
      end else begin : g_next
         assign sa     = a_q[k-1][k*CW +: CW];
         assign sb     = b_q[k-1][k*CW +: CW];
         assign ssub   = ctl_q[k-1].sub;
         assign scin   = ctl_q[k-1].carry;
         assign a_d[k] = a_q[k-1];
         assign b_d[k] = b_q[k-1];
         assign y_prev = y_q[k-1];
      end

      addsub_slice #(.CW(CW)) u_slice (
         .a        (sa),
         .b        (sb),
         .sub      (ssub),
         .cin      (scin),
         .s        (s),
         .cout     (scout),
         .c_msb_in (scmsb)
      );

      // Chunk k of y_prev is still zero, so OR-ing in the new sum chunk is safe.
      assign y_d[k]   = y_prev | (WIDTH'(s) << (k*CW));
      assign ctl_d[k] = '{carry: scout, sub: ssub, ovf: scmsb ^ scout};

      if (k == STAGES-1) begin : g_adv_last
         assign adv[k] = v_q[k] & Out_Ready;
      end else begin : g_adv_mid
         assign adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
      end

      if (k == 0) begin : g_load_first
         assign load[k] = In_Valid & In_Ready;
      end else begin : g_load_next
         assign load[k] = adv[k-1];
      end

      assign v_d[k] = load[k] | (v_q[k] & ~adv[k]);
   end

   assign In_Ready = ~v_q[0] | adv[0];

   always_ff @(posedge Clk or negedge Rst_) begin
      if (!Rst_) begin
         v_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            y_q[k]   <= '0;
            ctl_q[k] <= '0;
         end
      end else begin
         v_q <= v_d;
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               a_q[k]   <= a_d[k];
               b_q[k]   <= b_d[k];
               y_q[k]   <= y_d[k];
               ctl_q[k] <= ctl_d[k];
            end
         end
      end
   end

   assign Out_Valid = v_q[STAGES-1];
   assign Y         = y_q[STAGES-1];
   assign Cout      = ctl_q[STAGES-1].carry;
   assign Ovf       = ctl_q[STAGES-1].ovf;
   // Gated by valid so the flag reads 0 while empty and in reset.
   assign Zero      = v_q[STAGES-1] & ~|y_q[STAGES-1];

endmodule
